mdu_seq: RTL
============

# mdu_seq

Parametrised sequential multiply/divide unit for the MIPS core, sitting beside the combinational ALU in the execute stage. It handles MULT/MULTU/DIV/DIVU with a start/busy/done handshake and owns the architectural HI/LO registers, which MTHI/MTLO also write. The core stalls on `o_busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; legal values are 4..64.
- `i_clk`  in  1  rising-edge clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  operation request; sampled only while `o_busy`=0.
- `i_op`  in  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved and ignored.
- `i_op1`, `i_op2`  in  WIDTH  operands: multiplicand/multiplier, or dividend/divisor; `i_op1` is the MTHI/MTLO data.
- `o_busy`  out  1  high while a multiply or divide is in flight.
- `o_done`  out  1  one-cycle pulse when HI/LO have just been updated by a multiply or divide.
- `o_div_zero`  out  1  high together with `o_done` when the completed divide had a zero divisor.
- `o_hi`, `o_lo`  out  WIDTH  architectural HI/LO.

## Operation
- FSM has three states: IDLE, RUN, FIX.
- **IDLE**
  - `i_start` with op 000–011:
    - latch magnitudes of the operands (absolute value for signed ops, raw for unsigned);
    - latch result sign(s), the op, and the zero-divisor flag;
    - load the iteration counter with WIDTH; go to RUN.
  - `i_start` with MTHI/MTLO: write `i_op1` to HI/LO at this edge; stay in IDLE; no `o_done`.
  - Reserved op, or `i_start`=0: no effect.
- **RUN**: one iteration per cycle for WIDTH cycles, then go to FIX.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- **FIX**: apply sign correction, write HI/LO, assert `o_done` (registered); go to IDLE.
  - Multiply: {HI,LO} = full 2·WIDTH product, two's-complement negated when operand signs differ (signed only).
  - Divide: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
- Arithmetic rules:
  - The magnitude of the most-negative value is 2^(WIDTH-1), held unsigned in WIDTH bits with no overflow.
  - DIV most-negative / −1: LO = most-negative, HI = 0. No flag.
  - Divisor zero (DIV or DIVU): latency is unchanged. LO = all ones, HI = raw `i_op1`, and `o_div_zero`=1 during the `o_done` cycle.
- HI/LO change only in FIX, on MTHI/MTLO, or on reset. They hold their old values throughout RUN.
- While busy, `i_start` is ignored for all ops, including MTHI/MTLO. The issuing stage is responsible for re-presenting the request.
- Reserved op codes never change state or outputs.

## Timing
- Reset (async assert, sync release) takes effect immediately:
  - state = IDLE;
  - `o_hi` = `o_lo` = 0;
  - `o_busy` = `o_done` = `o_div_zero` = 0.
- Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- Start accepted at edge E0:
  - `o_busy`=1 from after E0 through the FIX cycle;
  - HI/LO are written at edge E0+WIDTH+1;
  - `o_done`=1 for exactly the cycle after that edge, with `o_busy`=0 in that same cycle.
- Total latency from the start edge to a valid result is WIDTH+1 cycles, constant for all ops and operand values.
- Back-to-back operation: `i_start` may be asserted in the `o_done` cycle and is accepted there. Zero idle cycles between operations.
- MTHI/MTLO: value visible on `o_hi`/`o_lo` one cycle after the accepting edge.
- `o_div_zero` is a pulse coincident with `o_done`. It is 0 at all other times.

## Test plan
All scenarios use WIDTH=32 unless stated otherwise.
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. `o_done` pulses exactly 33 cycles after the start edge, `o_busy` is high for 33 cycles, and HI/LO hold prior values until then.
2. MULT −3 × 7: HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000: HI=0x40000000, LO=0.
3. DIV −7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7: LO=14, HI=2. Issued back-to-back, with the second start in the first `o_done` cycle.
4. Divide corner cases:
   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, `o_div_zero`=0.
   - DIVU 5 / 0: LO=0xFFFFFFFF, HI=5, `o_div_zero`=1 only in the `o_done` cycle.
5. Handshake and MTHI/MTLO:
   - MTHI 0x1234 while idle: `o_hi`=0x1234 next cycle, with no `o_done`.
   - MTLO and MULT starts asserted during busy: ignored, so HI/LO and the final result are unaffected.
   - Op 110 while idle: no change.
6. Reset and width scaling:
   - Assert `i_rst_n`=0 ten cycles into a DIV: all outputs go to 0 immediately; after release, MULTU 3 × 5 gives LO=15, HI=0.
   - Rerun scenarios 2–4 with WIDTH=8, expecting latency 9.

Source files
------------

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit that owns the HI/LO registers.
// Multiply and divide each take WIDTH iterations plus one sign-fix cycle.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state_reg, state_next;

    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   mag_b_reg, raw_a_reg;
    logic               is_div_reg, neg_x_reg, neg_a_reg, zero_b_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, div_zero_reg;

    logic               accept_md, accept_mt, sgn_op, sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign accept_md = (state_reg == IDLE) && i_start && !i_op[2];
    assign accept_mt = (state_reg == IDLE) && i_start && i_op[2] && !i_op[1];
    assign sgn_op    = !i_op[0];
    assign sgn_a     = sgn_op && i_op1[WIDTH-1];
    assign sgn_b     = sgn_op && i_op2[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is its magnitude.
    assign mag_a     = sgn_a ? -i_op1 : i_op1;
    assign mag_b     = sgn_b ? -i_op2 : i_op2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_md) state_next = RUN;
            RUN:     if (cnt_reg == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration step; both algorithms share the 2*WIDTH accumulator.
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic             q_bit;
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
        if (acc_reg[0]) mul_sum = mul_sum + {1'b0, mag_b_reg};
        div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, mag_b_reg};
        q_bit     = !div_trial[WIDTH];
        if (is_div_reg)
            acc_next = {(q_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], q_bit};
        else
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    always_comb begin
        prod_fix = neg_x_reg ? -acc_reg : acc_reg;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_reg) begin
            if (zero_b_reg) begin
                fix_hi = raw_a_reg;
                fix_lo = '1;
            end else begin
                fix_hi = neg_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
                fix_lo = neg_x_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            mag_b_reg    <= '0;
            raw_a_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_x_reg    <= 1'b0;
            neg_a_reg    <= 1'b0;
            zero_b_reg   <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept_md) begin
                        cnt_reg    <= CW'(WIDTH);
                        acc_reg    <= {{WIDTH{1'b0}}, mag_a};
                        mag_b_reg  <= mag_b;
                        raw_a_reg  <= i_op1;
                        is_div_reg <= i_op[1];
                        neg_x_reg  <= sgn_a ^ sgn_b;
                        neg_a_reg  <= sgn_a;
                        zero_b_reg <= (i_op2 == '0);
                    end
                    if (accept_mt && !i_op[0]) hi_reg <= i_op1;
                    if (accept_mt &&  i_op[0]) lo_reg <= i_op1;
                end
                RUN: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    acc_reg <= acc_next;
                end
                FIX: begin
                    hi_reg       <= fix_hi;
                    lo_reg       <= fix_lo;
                    done_reg     <= 1'b1;
                    div_zero_reg <= is_div_reg && zero_b_reg;
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (state_reg != IDLE);
    assign o_done     = done_reg;
    assign o_div_zero = div_zero_reg;
    assign o_hi       = hi_reg;
    assign o_lo       = lo_reg;
endmodule
